// File: rtl/fp_add_sub_seq_core_if.sv
// Add/sub request/response bundle between a requester (master) and the sequential FP core (slave).
// Handshake: operands transfer on a rising clock edge where start_in && ready_out; done_out pulses one cycle when floating_addition_out updates.
interface fp_add_sub_seq_core_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start_in;
  logic                  ready_out;
  logic                  opcode_in;
  logic [DATA_WIDTH-1:0] floating1_in;
  logic [DATA_WIDTH-1:0] floating2_in;
  logic [DATA_WIDTH-1:0] floating_addition_out;
  logic                  done_out;
  logic [2:0]            dbg_state;

  modport master (
    output start_in, opcode_in, floating1_in, floating2_in,
    input  ready_out, floating_addition_out, done_out, dbg_state
  );

  modport slave (
    input  start_in, opcode_in, floating1_in, floating2_in,
    output ready_out, floating_addition_out, done_out, dbg_state
  );
endinterface

// File: rtl/fp_add_sub_seq_core.sv
// Multi-cycle binary32 adder/subtractor: one-bit-per-clock alignment and normalisation,
// round-to-nearest-even, denormals flushed to zero on input and output.
module fp_add_sub_seq_core #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_ALIGN  = 26
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  fp_add_sub_seq_core_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_SPECIAL, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t                r_state;
  logic                  r_ready;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_out;
  logic [DATA_WIDTH-1:0] r_f1;
  logic [DATA_WIDTH-1:0] r_f2;
  logic                  r_op;
  logic                  r_sa, r_sb, r_s;
  logic [7:0]            r_ea, r_eb, r_diff;
  logic [26:0]           r_ma, r_mb;
  logic                  r_nan, r_inf_a, r_inf_b;
  logic [27:0]           r_sum;
  logic [9:0]            r_e;
  logic [31:0]           r_res;

  // Operand decode for UNPACK: denormals read as zero, A is the larger magnitude.
  logic [7:0]  w_e1, w_e2, w_ea, w_eb;
  logic [22:0] w_fr1, w_fr2, w_fra, w_frb;
  logic        w_s2e, w_swap, w_sa, w_sb;
  logic        w_nan, w_inf_a, w_inf_b;
  logic [26:0] w_ma, w_mb;

  assign w_e1    = r_f1[30:23];
  assign w_e2    = r_f2[30:23];
  assign w_fr1   = (w_e1 == 8'd0) ? 23'd0 : r_f1[22:0];
  assign w_fr2   = (w_e2 == 8'd0) ? 23'd0 : r_f2[22:0];
  assign w_s2e   = r_f2[31] ^ r_op;
  assign w_swap  = {w_e2, w_fr2} > {w_e1, w_fr1};
  assign w_sa    = w_swap ? w_s2e  : r_f1[31];
  assign w_sb    = w_swap ? r_f1[31] : w_s2e;
  assign w_ea    = w_swap ? w_e2  : w_e1;
  assign w_eb    = w_swap ? w_e1  : w_e2;
  assign w_fra   = w_swap ? w_fr2 : w_fr1;
  assign w_frb   = w_swap ? w_fr1 : w_fr2;
  assign w_ma    = {(w_ea != 8'd0), w_fra, 3'b000};
  assign w_mb    = {(w_eb != 8'd0), w_frb, 3'b000};
  assign w_nan   = ((w_e1 == 8'hFF) && (r_f1[22:0] != 23'd0)) ||
                   ((w_e2 == 8'hFF) && (r_f2[22:0] != 23'd0));
  assign w_inf_a = (w_ea == 8'hFF);
  assign w_inf_b = (w_eb == 8'hFF);

  logic [31:0] w_sres;
  always_comb begin
    w_sres = {r_sa, r_ea, r_ma[25:3]};
    if (r_nan)
      w_sres = 32'h7FC00000;
    else if (r_inf_a && r_inf_b && (r_sa != r_sb))
      w_sres = 32'h7FC00000;
    else if (r_inf_a)
      w_sres = {r_sa, 8'hFF, 23'd0};
    else if (r_ea == 8'd0)
      w_sres = {r_sa & r_sb, 31'd0};
  end

  logic [27:0] w_sum;
  assign w_sum = (r_sa == r_sb) ? ({1'b0, r_ma} + {1'b0, r_mb})
                                : ({1'b0, r_ma} - {1'b0, r_mb});

  // Rounding: bits [26:3] are the significand, [2:0] guard/round/sticky.
  logic        w_up;
  logic [24:0] w_rnd;
  logic [9:0]  w_rexp;
  logic [22:0] w_rman;
  logic [31:0] w_rres;
  assign w_up   = r_sum[2] & (r_sum[1] | r_sum[0] | r_sum[3]);
  assign w_rnd  = {1'b0, r_sum[26:3]} + {24'd0, w_up};
  assign w_rexp = r_e + {9'd0, w_rnd[24]};
  assign w_rman = w_rnd[24] ? w_rnd[23:1] : w_rnd[22:0];
  assign w_rres = (w_rexp >= 10'd255) ? {r_s, 8'hFF, 23'd0}
                                      : {r_s, w_rexp[7:0], w_rman};

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_out   <= '0;
      r_f1    <= '0;
      r_f2    <= '0;
      r_op    <= 1'b0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_s     <= 1'b0;
      r_ea    <= 8'd0;
      r_eb    <= 8'd0;
      r_diff  <= 8'd0;
      r_ma    <= 27'd0;
      r_mb    <= 27'd0;
      r_nan   <= 1'b0;
      r_inf_a <= 1'b0;
      r_inf_b <= 1'b0;
      r_sum   <= 28'd0;
      r_e     <= 10'd0;
      r_res   <= 32'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start_in && r_ready) begin
            r_f1    <= bus.floating1_in;
            r_f2    <= bus.floating2_in;
            r_op    <= bus.opcode_in;
            r_ready <= 1'b0;
            r_state <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          r_sa    <= w_sa;
          r_sb    <= w_sb;
          r_ea    <= w_ea;
          r_eb    <= w_eb;
          r_ma    <= w_ma;
          r_mb    <= w_mb;
          r_nan   <= w_nan;
          r_inf_a <= w_inf_a;
          r_inf_b <= w_inf_b;
          r_diff  <= w_ea - w_eb;
          r_state <= (w_nan || w_inf_a || w_inf_b || (w_eb == 8'd0)) ? S_SPECIAL : S_ALIGN;
        end
        S_SPECIAL: begin
          r_res   <= w_sres;
          r_state <= S_DONE;
        end
        S_ALIGN: begin
          if (r_diff > 8'(MAX_ALIGN)) begin
            r_mb    <= {26'd0, |r_mb};
            r_diff  <= 8'd0;
            r_state <= S_ADD;
          end else if (r_diff == 8'd0) begin
            r_state <= S_ADD;
          end else begin
            r_mb   <= {1'b0, r_mb[26:2], r_mb[1] | r_mb[0]};
            r_diff <= r_diff - 8'd1;
            if (r_diff == 8'd1)
              r_state <= S_ADD;
          end
        end
        S_ADD: begin
          if (w_sum == 28'd0) begin
            r_res   <= 32'd0;
            r_state <= S_DONE;
          end else begin
            r_sum   <= w_sum;
            r_e     <= {2'b00, r_ea};
            r_s     <= r_sa;
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          if (r_sum[27]) begin
            r_sum   <= {1'b0, r_sum[27:2], r_sum[1] | r_sum[0]};
            r_e     <= r_e + 10'd1;
            r_state <= S_ROUND;
          end else if (r_sum[26]) begin
            r_state <= S_ROUND;
          end else if (r_e == 10'd1) begin
            // Next shift would need exponent 0: no denormal output, flush.
            r_res   <= {r_s, 31'd0};
            r_state <= S_DONE;
          end else begin
            r_sum <= {r_sum[26:0], 1'b0};
            r_e   <= r_e - 10'd1;
            if (r_sum[25])
              r_state <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_res   <= w_rres;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_out   <= r_res;
          r_done  <= 1'b1;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready_out             = r_ready;
  assign bus.done_out              = r_done;
  assign bus.floating_addition_out = r_out;
  assign bus.dbg_state             = r_state;

endmodule
